// File: rtl/data_sram_bank.sv
// Parametrised single-port data SRAM with byte enables, read latency and address checks.
// Array contents are uninitialised until written.
module data_sram_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "dmem.hex"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic                    WriteEn,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  input  logic                    ReadEn,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    Busy,
  output logic                    AddrErr
);

  localparam int NumBytes = DATA_WIDTH / 8;
  localparam int ByteSh   = $clog2(NumBytes);
  localparam int IdxW     = $clog2(DEPTH);
  localparam int CntW     = 2;
  localparam logic [ADDR_WIDTH-1:0] AlignMask =
    ADDR_WIDTH'((1 << ByteSh) - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, stateNext;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pendData;
  logic [CntW-1:0]       cnt;
  logic [IdxW-1:0]       idx;
  logic                  addrBad;
  logic                  wrGo;
  logic                  rdGo;
  logic                  errGo;

  assign idx     = Address[ByteSh +: IdxW];
  assign addrBad = ((Address & AlignMask) != '0) ||
                   ((Address >> (ByteSh + IdxW)) != '0);
  assign wrGo    = !Busy && WriteEn && !addrBad;
  assign rdGo    = !Busy && ReadEn && !WriteEn && !addrBad;
  assign errGo   = !Busy && (WriteEn || ReadEn) && addrBad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, RESP: begin
        if (rdGo) stateNext = (READ_LATENCY == 1) ? RESP : WAIT;
        else      stateNext = IDLE;
      end
      WAIT: if (cnt == '0) stateNext = RESP;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ReadValid = (state == RESP);
    Busy      = (state == WAIT);
  end

  // Counter holds the remaining WAIT edges minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      pendData <= '0;
      ReadData <= '0;
      AddrErr  <= 1'b0;
    end else begin
      AddrErr <= errGo;
      if (rdGo) begin
        cnt      <= CntW'(READ_LATENCY - 2);
        pendData <= mem[idx];
        if (READ_LATENCY == 1) ReadData <= mem[idx];
      end else if (state == WAIT) begin
        if (cnt == '0) ReadData <= pendData;
        else           cnt      <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (wrGo && ByteEn[i]) mem[idx][8*i +: 8] <= WriteData[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_sram_bank.sv
// Bench for data_sram_bank: latency-1 and latency-3 instances on shared stimulus,
// checked against a word-array model of the memory and the latency timeline.
module tb_data_sram_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WriteEn;
  logic [3:0]  ByteEn;
  logic        ReadEn;

  logic [31:0] rd1, rd3;
  logic        rv1, rv3, bz1, bz3, ae1, ae3;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] model [int];
  logic [31:0] last1 = '0;
  logic [31:0] last3 = '0;

  data_sram_bank #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
    .WriteEn(WriteEn), .ByteEn(ByteEn), .ReadEn(ReadEn),
    .ReadData(rd1), .ReadValid(rv1), .Busy(bz1), .AddrErr(ae1)
  );

  data_sram_bank #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
    .WriteEn(WriteEn), .ByteEn(ByteEn), .ReadEn(ReadEn),
    .ReadData(rd3), .ReadValid(rv3), .Busy(bz3), .AddrErr(ae3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    WriteEn = 1'b0;
    ReadEn  = 1'b0;
    ByteEn  = '0;
  endtask

  task automatic edgeWait();
    @(posedge clk);
    #1;
  endtask

  // One request presented for a single edge, then the full L3 timeline checked.
  task automatic doOp(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    bit          bad;
    bit          rd;
    logic [31:0] exp;
    logic [31:0] w;
    bad = (a % 4 != 0) || (a >= 1024);
    rd  = re && !we && !bad;
    exp = '0;
    if (we && !bad) begin
      w = model.exists(a / 4) ? model[a / 4] : 32'hx;
      for (int i = 0; i < 4; i++)
        if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[a / 4] = w;
    end
    if (rd) begin
      exp   = model[a / 4];
      last1 = exp;
    end
    Address = a; WriteData = wd; WriteEn = we; ReadEn = re; ByteEn = be;
    edgeWait();
    idle();
    chk("rv1_e0", {31'b0, rv1}, {31'b0, rd});
    chk("rd1_e0", rd1, last1);
    chk("ae1_e0", {31'b0, ae1}, {31'b0, bad && (we || re)});
    chk("ae3_e0", {31'b0, ae3}, {31'b0, bad && (we || re)});
    chk("bz3_e0", {31'b0, bz3}, {31'b0, rd});
    chk("rv3_e0", {31'b0, rv3}, 32'd0);
    edgeWait();
    chk("bz3_e1", {31'b0, bz3}, {31'b0, rd});
    chk("rv3_e1", {31'b0, rv3}, 32'd0);
    chk("rv1_e1", {31'b0, rv1}, 32'd0);
    chk("ae1_e1", {31'b0, ae1}, 32'd0);
    edgeWait();
    if (rd) last3 = exp;
    chk("rv3_e2", {31'b0, rv3}, {31'b0, rd});
    chk("bz3_e2", {31'b0, bz3}, 32'd0);
    chk("rd3_e2", rd3, last3);
    edgeWait();
    chk("rv3_e3", {31'b0, rv3}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1;
    idle();
    Address = '0; WriteData = '0;
    edgeWait();
    edgeWait();
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd3", rd3, 32'd0);
    chk("rst_rv", {30'b0, rv1, rv3}, 32'd0);
    chk("rst_bz", {30'b0, bz1, bz3}, 32'd0);
    chk("rst_ae", {30'b0, ae1, ae3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      doOp(1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF);

    doOp(1'b1, 1'b0, 32'h3C, 32'h0000_0001, 4'hF);
    doOp(1'b0, 1'b1, 32'h3C, '0, 4'h0);
    chk("wr_rd_const", rd1, 32'h0000_0001);

    doOp(1'b1, 1'b0, 32'h10, 32'hAABB_CCDD, 4'hF);
    doOp(1'b1, 1'b0, 32'h10, 32'h1122_3344, 4'b0101);
    doOp(1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'b0000);
    doOp(1'b0, 1'b1, 32'h10, '0, 4'h0);
    chk("lanes_const", rd3, 32'hAA22_CC44);

    doOp(1'b1, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 4'hF);
    doOp(1'b0, 1'b1, 32'h0000_0000, '0, 4'h0);
    doOp(1'b0, 1'b1, 32'h0000_0400, '0, 4'h0);

    doOp(1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A, 4'hF);
    doOp(1'b0, 1'b1, 32'h20, '0, 4'h0);
    chk("collide_const", rd3, 32'h5A5A_5A5A);

    // L3 busy window: held request ignored, next read taken in the valid cycle
    a = model[5];
    b = model[9];
    Address = 32'h14; ReadEn = 1'b1;
    edgeWait();
    Address = 32'h18;
    chk("bz_hold0", {31'b0, bz3}, 32'd1);
    edgeWait();
    chk("bz_hold1", {31'b0, bz3}, 32'd1);
    edgeWait();
    Address = 32'h24;
    chk("b2b_rv0", {31'b0, rv3}, 32'd1);
    chk("b2b_rd0", rd3, a);
    edgeWait();
    idle();
    chk("b2b_bz", {31'b0, bz3}, 32'd1);
    chk("b2b_hold", rd3, a);
    edgeWait();
    edgeWait();
    chk("b2b_rv1", {31'b0, rv3}, 32'd1);
    chk("b2b_rd1", rd3, b);
    last3 = b;
    edgeWait();
    last1 = rd1;

    // Async reset one edge after an L3 read accept
    Address = 32'h28; ReadEn = 1'b1;
    edgeWait();
    idle();
    edgeWait();
    chk("mid_bz", {31'b0, bz3}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rv", {30'b0, rv1, rv3}, 32'd0);
    chk("arst_bz", {31'b0, bz3}, 32'd0);
    chk("arst_rd3", rd3, 32'd0);
    chk("arst_rd1", rd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last1 = '0;
    last3 = '0;
    for (int i = 0; i < 4; i++) begin
      edgeWait();
      chk("post_rst_rv3", {31'b0, rv3}, 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic        we;
      logic        re;
      ra = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) ra = ra + 32'h400 * 32'($urandom_range(1, 4));
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      doOp(we, re, ra, $urandom, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
